// File: rtl/imem_dmem_arbiter_if.sv
// Shared memory port bundle between the fetch unit, the load/store
// unit, the arbiter and the memory model.
interface imem_dmem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic        ls_err;
    logic [31:0] ls_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        input  mem_rdata, mem_ready,
        output if_ack, if_err, if_rdata,
        output ls_ack, ls_err, ls_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
        output mem_rdata, mem_ready,
        input  if_ack, if_err, if_rdata,
        input  ls_ack, ls_err, ls_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between
// instruction fetch and load/store, with alignment checks and timeout.
module imem_dmem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic reset,
    imem_dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_ls;
    logic             r_gnt_ls;
    logic             r_if_ack, r_if_err;
    logic             r_ls_ack, r_ls_err;
    logic [31:0]      r_if_rdata, r_ls_rdata;
    logic             r_mem_req, r_mem_we;
    logic [3:0]       r_mem_be;
    logic [31:0]      r_mem_addr, r_mem_wdata;

    logic             w_any, w_gnt_ls;
    logic             w_if_bad, w_ls_bad, w_bad;
    logic             w_tmo, w_fin, w_fin_ls, w_fin_err;
    logic [31:0]      w_fin_rdata;
    logic [31:2]      w_addr;

    always_comb begin
        w_any    = bus.if_req || bus.ls_req;
        // tie goes to whichever port was not served last
        w_gnt_ls = bus.ls_req && (!bus.if_req || !r_last_ls);
        w_addr   = w_gnt_ls ? bus.ls_addr[31:2] : bus.if_addr[31:2];
        w_if_bad = bus.if_addr[1:0] != 2'b00;
        case (bus.ls_be)
            4'b1111:          w_ls_bad = bus.ls_addr[1:0] != 2'b00;
            4'b0011, 4'b1100: w_ls_bad = bus.ls_addr[0];
            4'b0001, 4'b0010,
            4'b0100, 4'b1000: w_ls_bad = 1'b0;
            default:          w_ls_bad = 1'b1;
        endcase
        w_bad = w_gnt_ls ? w_ls_bad : w_if_bad;
        w_tmo = (TIMEOUT != 0) && (r_cnt + 1'b1 == LP_TMO);
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = w_bad ? S_RESP : S_BUSY;
            S_BUSY:  if (bus.mem_ready || w_tmo) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_fin       = (w_next == S_RESP) && (r_state != S_RESP);
        w_fin_ls    = (r_state == S_IDLE) ? w_gnt_ls : r_gnt_ls;
        w_fin_err   = (r_state == S_IDLE) || !bus.mem_ready;
        w_fin_rdata = 32'h0;
        if (r_state == S_BUSY && bus.mem_ready && !r_mem_we)
            w_fin_rdata = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_last_ls   <= 1'b0;
            r_gnt_ls    <= 1'b0;
            r_if_ack    <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_ls_ack    <= 1'b0;
            r_ls_err    <= 1'b0;
            r_ls_rdata  <= 32'h0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
        end else begin
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: if (w_any) begin
                    r_gnt_ls <= w_gnt_ls;
                    r_cnt    <= '0;
                    if (!w_bad) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_gnt_ls && bus.ls_we;
                        r_mem_be    <= w_gnt_ls ? bus.ls_be : 4'hF;
                        r_mem_addr  <= {w_addr, 2'b00};
                        r_mem_wdata <= w_gnt_ls ? bus.ls_wdata : 32'h0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_fin) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                S_RESP:  r_last_ls <= r_gnt_ls;
                default: ;
            endcase
            if (w_fin && w_fin_ls) begin
                r_ls_ack   <= 1'b1;
                r_ls_err   <= w_fin_err;
                r_ls_rdata <= w_fin_rdata;
            end else if (w_fin) begin
                r_if_ack   <= 1'b1;
                r_if_err   <= w_fin_err;
                r_if_rdata <= w_fin_rdata;
            end
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_err    = r_if_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ls_ack    = r_ls_ack;
    assign bus.ls_err    = r_ls_err;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: fetch, contention, lane checks,
// timeout and asynchronous reset during an access.
module tb_imem_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   lat = 0;
    int   wcnt = 0;

    imem_dmem_arbiter_if bus();

    imem_dmem_arbiter #(
        .TIMEOUT(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00500093 : {a[15:0], 16'hC0DE};
    endfunction

    // lat: mem_ready asserted on the lat-th mem_req cycle; 0 = never
    always_comb begin
        bus.mem_rdata = model_rd(bus.mem_addr);
        bus.mem_ready = bus.mem_req && (lat != 0) && (wcnt == lat - 1);
    end

    always @(posedge clk)
        wcnt <= (bus.mem_req && !bus.mem_ready) ? wcnt + 1 : 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.if_req   = 1'b0;
        bus.if_addr  = 32'h0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_be    = 4'h0;
        bus.ls_addr  = 32'h0;
        bus.ls_wdata = 32'h0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle_inputs();
        lat = 1;
        tick();
        tick();
        total++;
        if ({bus.if_ack, bus.if_err, bus.ls_ack, bus.ls_err,
             bus.mem_req, bus.mem_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                {bus.if_ack, bus.if_err, bus.ls_ack, bus.ls_err,
                 bus.mem_req, bus.mem_we});
        end
        total++;
        if ({bus.if_rdata, bus.ls_rdata, bus.mem_addr,
             bus.mem_wdata, bus.mem_be} !== 132'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0",
                {bus.if_rdata, bus.ls_rdata, bus.mem_addr,
                 bus.mem_wdata, bus.mem_be});
        end
        reset = 1'b1;
        tick();
        total++;
        if (bus.mem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_noreq got=%b want=0", bus.mem_req);
        end
    endtask

    task automatic test_fetch;
        lat = 1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        tick();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.if_ack}
            !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b0}) begin
            bad++;
            $display("FAIL fetch_bus got=%b/%b/%h/%h/%b want=1/0/f/100/0",
                bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr,
                bus.if_ack);
        end
        tick();
        total++;
        if ({bus.if_ack, bus.if_err, bus.ls_ack, bus.mem_req}
            !== 4'b1000) begin
            bad++;
            $display("FAIL fetch_ack got=%b want=1000",
                {bus.if_ack, bus.if_err, bus.ls_ack, bus.mem_req});
        end
        total++;
        if (bus.if_rdata !== 32'h00500093) begin
            bad++;
            $display("FAIL fetch_rdata got=%h want=00500093", bus.if_rdata);
        end
        bus.if_req = 1'b0;
        tick();
        total++;
        if ({bus.if_ack, bus.if_rdata} !== {1'b0, 32'h00500093}) begin
            bad++;
            $display("FAIL fetch_hold got=%b/%h want=0/00500093",
                bus.if_ack, bus.if_rdata);
        end
    endtask

    task automatic test_if_misaligned;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h102;
        tick();
        total++;
        if ({bus.if_ack, bus.if_err, bus.mem_req, bus.if_rdata}
            !== {3'b110, 32'h0}) begin
            bad++;
            $display("FAIL if_misalign got=%b%b%b/%h want=110/0",
                bus.if_ack, bus.if_err, bus.mem_req, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        tick();
        total++;
        if (bus.if_ack !== 1'b0) begin
            bad++;
            $display("FAIL if_ack_pulse got=%b want=0", bus.if_ack);
        end
    endtask

    task automatic test_contention;
        logic e_ls, e_if;
        reset = 1'b0;
        lat = 2;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_be   = 4'hF;
        bus.ls_addr = 32'h2000;
        tick();
        reset = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            e_ls = (c % 4 == 3) && ((c / 4) % 2 == 0);
            e_if = (c % 4 == 3) && ((c / 4) % 2 == 1);
            total++;
            if ({bus.if_ack, bus.ls_ack} !== {e_if, e_ls}) begin
                bad++;
                $display("FAIL rr_ack c=%0d got=%b%b want=%b%b",
                    c, bus.if_ack, bus.ls_ack, e_if, e_ls);
            end
            total++;
            if ((bus.mem_req & (bus.if_ack | bus.ls_ack)) !== 1'b0) begin
                bad++;
                $display("FAIL rr_req_in_resp c=%0d got=1 want=0", c);
            end
            if (e_ls) begin
                total++;
                if (bus.ls_rdata !== 32'h2000C0DE) begin
                    bad++;
                    $display("FAIL rr_ls_rdata got=%h want=2000c0de",
                        bus.ls_rdata);
                end
            end
            if (e_if) begin
                total++;
                if (bus.if_rdata !== 32'h0104C0DE) begin
                    bad++;
                    $display("FAIL rr_if_rdata got=%h want=0104c0de",
                        bus.if_rdata);
                end
            end
            if (c == 1 || c == 5) begin
                total++;
                if (bus.mem_addr !== ((c == 1) ? 32'h2000 : 32'h104)) begin
                    bad++;
                    $display("FAIL rr_grant c=%0d got=%h", c, bus.mem_addr);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_byte_store;
        lat = 1;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_be    = 4'b1000;
        bus.ls_addr  = 32'h2003;
        bus.ls_wdata = 32'hAB000000;
        tick();
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr,
             bus.mem_wdata} !== {2'b11, 4'b1000, 32'h2000, 32'hAB000000})
        begin
            bad++;
            $display("FAIL sb_bus got=%b%b/%b/%h/%h want=11/1000/2000/ab000000",
                bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr,
                bus.mem_wdata);
        end
        tick();
        total++;
        if ({bus.ls_ack, bus.ls_err, bus.mem_we, bus.ls_rdata}
            !== {3'b100, 32'h0}) begin
            bad++;
            $display("FAIL sb_ack got=%b%b%b/%h want=100/0",
                bus.ls_ack, bus.ls_err, bus.mem_we, bus.ls_rdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ls_checks;
        logic [31:0] va [7];
        logic [3:0]  vb [7];
        logic        ve [7];
        logic [31:0] wa;
        va = '{32'h2002, 32'h2002, 32'h2000, 32'h2001,
               32'h2004, 32'h2001, 32'h2008};
        vb = '{4'b0011, 4'b1111, 4'b0000, 4'b0011,
               4'b0101, 4'b0010, 4'b1100};
        ve = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        lat = 1;
        for (int i = 0; i < 7; i++) begin
            wa = {va[i][31:2], 2'b00};
            bus.ls_req  = 1'b1;
            bus.ls_we   = 1'b0;
            bus.ls_addr = va[i];
            bus.ls_be   = vb[i];
            tick();
            if (ve[i]) begin
                total++;
                if ({bus.ls_ack, bus.ls_err, bus.mem_req, bus.ls_rdata}
                    !== {3'b110, 32'h0}) begin
                    bad++;
                    $display("FAIL lschk_err i=%0d got=%b%b%b/%h want=110/0",
                        i, bus.ls_ack, bus.ls_err, bus.mem_req,
                        bus.ls_rdata);
                end
            end else begin
                total++;
                if ({bus.ls_ack, bus.mem_req, bus.mem_be, bus.mem_addr}
                    !== {2'b01, vb[i], wa}) begin
                    bad++;
                    $display("FAIL lschk_bus i=%0d got=%b%b/%b/%h want=01/%b/%h",
                        i, bus.ls_ack, bus.mem_req, bus.mem_be,
                        bus.mem_addr, vb[i], wa);
                end
                tick();
                total++;
                if ({bus.ls_ack, bus.ls_err, bus.ls_rdata}
                    !== {2'b10, model_rd(wa)}) begin
                    bad++;
                    $display("FAIL lschk_ack i=%0d got=%b%b/%h want=10/%h",
                        i, bus.ls_ack, bus.ls_err, bus.ls_rdata,
                        model_rd(wa));
                end
            end
            bus.ls_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_timeout;
        lat = 0;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_be   = 4'hF;
        bus.ls_addr = 32'h3000;
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++;
            if (c <= 4 && {bus.mem_req, bus.ls_ack} !== 2'b10) begin
                bad++;
                $display("FAIL tmo_wait c=%0d got=%b%b want=10",
                    c, bus.mem_req, bus.ls_ack);
            end else if (c == 5 &&
                {bus.mem_req, bus.ls_ack, bus.ls_err, bus.ls_rdata}
                !== {3'b011, 32'h0}) begin
                bad++;
                $display("FAIL tmo_ack got=%b%b%b/%h want=011/0",
                    bus.mem_req, bus.ls_ack, bus.ls_err, bus.ls_rdata);
            end
        end
        bus.ls_req = 1'b0;
        tick();
        lat = 1;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h2000;
        tick();
        tick();
        total++;
        if ({bus.ls_ack, bus.ls_err, bus.ls_rdata}
            !== {2'b10, 32'h2000C0DE}) begin
            bad++;
            $display("FAIL tmo_after got=%b%b/%h want=10/2000c0de",
                bus.ls_ack, bus.ls_err, bus.ls_rdata);
        end
        bus.ls_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop;
        lat = 1;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_be   = 4'hF;
        bus.ls_addr = 32'h2004;
        tick();
        tick();
        bus.ls_req = 1'b0;
        tick();
        lat = 0;
        bus.ls_req = 1'b1;
        tick();
        tick();
        total++;
        if (bus.mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_busy got=%b want=1", bus.mem_req);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_we, bus.ls_ack, bus.if_ack,
             bus.ls_err, bus.if_err} !== 6'b0) begin
            bad++;
            $display("FAIL rst_async_flags got=%b want=000000",
                {bus.mem_req, bus.mem_we, bus.ls_ack, bus.if_ack,
                 bus.ls_err, bus.if_err});
        end
        total++;
        if ({bus.ls_rdata, bus.if_rdata, bus.mem_addr, bus.mem_be}
            !== 100'h0) begin
            bad++;
            $display("FAIL rst_async_data got=%h want=0",
                {bus.ls_rdata, bus.if_rdata, bus.mem_addr, bus.mem_be});
        end
        lat = 1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        bus.ls_addr = 32'h2000;
        bus.ls_be   = 4'b0011;
        tick();
        total++;
        if ({bus.ls_ack, bus.if_ack, bus.mem_req} !== 3'b000) begin
            bad++;
            $display("FAIL rst_no_ack got=%b want=000",
                {bus.ls_ack, bus.if_ack, bus.mem_req});
        end
        reset = 1'b1;
        tick();
        total++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be}
            !== {1'b1, 32'h2000, 4'b0011}) begin
            bad++;
            $display("FAIL rst_tie_ls got=%b/%h/%b want=1/2000/0011",
                bus.mem_req, bus.mem_addr, bus.mem_be);
        end
        tick();
        total++;
        if ({bus.ls_ack, bus.if_ack} !== 2'b10) begin
            bad++;
            $display("FAIL rst_tie_ack got=%b%b want=10",
                bus.ls_ack, bus.if_ack);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_if_misaligned();
        test_contention();
        test_byte_store();
        test_ls_checks();
        test_timeout();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
